// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: control-unit <-> datapath/memory bundle
//   opcode, zero, mem_ready        : datapath/memory -> control
//   pc_write .. alu_src_a          : 1-bit datapath controls
//   alu_src_b, alu_op, pc_source   : 2-bit mux selects / ALU op class
interface mc_control_fsm_if;
   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
   logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_source;
   modport master (
      input  opcode, zero, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_source
   );
   modport slave (
      output opcode, zero, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write,
             ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a,
             alu_src_b, alu_op, pc_source
   );
endinterface

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle MIPS control unit with memory-wait timeout and retired-instruction counter
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   bus         : datapath controls and opcode/zero/mem_ready inputs
//   state       : current state encoding
//   illegal_op  : one-cycle pulse on unsupported opcode in DECODE
//   mem_timeout : one-cycle pulse when a memory wait hits MEM_WAIT_MAX
//   instr_count : retired instructions, wraps
module mc_control_fsm #(
   parameter int MEM_WAIT_MAX = 15
) (
   input  logic              clk,
   input  logic              reset,
   mc_control_fsm_if.master  bus,
   output logic [3:0]        state,
   output logic              illegal_op,
   output logic              mem_timeout,
   output logic [31:0]       instr_count
);
   typedef enum logic [3:0] {
      FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
      RTYPE_EX = 4'd6, RTYPE_WB = 4'd7, BEQ = 4'd8, JUMP = 4'd9, ADDI_EX = 4'd10, ADDI_WB = 4'd11
   } state_t;
   state_t     cur, nxt;
   logic [3:0] wait_cnt;
   logic       waiting, retire;
   assign state   = cur;
   assign waiting = (cur == FETCH || cur == MEMRD || cur == MEMWR) && !bus.mem_ready;
   assign mem_timeout = waiting && wait_cnt == 4'(MEM_WAIT_MAX - 1);
   assign retire  = cur == MEMWB || cur == RTYPE_WB || cur == BEQ || cur == JUMP || cur == ADDI_WB
                    || (cur == MEMWR && bus.mem_ready);
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         cur         <= FETCH;
         instr_count <= '0;
         wait_cnt    <= '0;
      end else begin
         cur         <= nxt;
         instr_count <= instr_count + 32'(retire);
         wait_cnt    <= (waiting && !mem_timeout) ? wait_cnt + 4'd1 : 4'd0;
      end
   always_comb begin
      nxt               = FETCH;
      illegal_op        = 1'b0;
      bus.pc_write      = 1'b0;
      bus.pc_write_cond = 1'b0;
      bus.iord          = 1'b0;
      bus.mem_read      = 1'b0;
      bus.mem_write     = 1'b0;
      bus.ir_write      = 1'b0;
      bus.mem_to_reg    = 1'b0;
      bus.reg_dst       = 1'b0;
      bus.reg_write     = 1'b0;
      bus.alu_src_a     = 1'b0;
      bus.alu_src_b     = 2'b00;
      bus.alu_op        = 2'b00;
      bus.pc_source     = 2'b00;
      case (cur)
         FETCH: begin
            bus.mem_read  = 1'b1;
            bus.alu_src_b = 2'b01;
            // reset gating keeps the Mealy write term quiet while reset is held
            bus.ir_write  = bus.mem_ready && reset;
            bus.pc_write  = bus.mem_ready && reset;
            nxt           = bus.mem_ready ? DECODE : FETCH;
         end
         DECODE: begin
            bus.alu_src_b = 2'b11;
            case (bus.opcode)
               6'b000000:           nxt = RTYPE_EX;
               6'b100011, 6'b101011: nxt = MEMADR;
               6'b000100:           nxt = BEQ;
               6'b000010:           nxt = JUMP;
               6'b001000:           nxt = ADDI_EX;
               default:             illegal_op = 1'b1;
            endcase
         end
         MEMADR: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            // IR still holds the instruction; bit 29 separates sw from lw
            nxt           = bus.opcode[3] ? MEMWR : MEMRD;
         end
         MEMRD: begin
            bus.mem_read = 1'b1;
            bus.iord     = 1'b1;
            nxt          = bus.mem_ready ? MEMWB : MEMRD;
         end
         MEMWB: begin
            bus.reg_write  = 1'b1;
            bus.mem_to_reg = 1'b1;
         end
         MEMWR: begin
            bus.mem_write = !mem_timeout;
            bus.iord      = 1'b1;
            nxt           = bus.mem_ready ? FETCH : MEMWR;
         end
         RTYPE_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_op    = 2'b10;
            nxt           = RTYPE_WB;
         end
         RTYPE_WB: begin
            bus.reg_write = 1'b1;
            bus.reg_dst   = 1'b1;
         end
         BEQ: begin
            bus.alu_src_a     = 1'b1;
            bus.alu_op        = 2'b01;
            bus.pc_write_cond = 1'b1;
            bus.pc_source     = 2'b01;
         end
         JUMP: begin
            bus.pc_write  = 1'b1;
            bus.pc_source = 2'b10;
         end
         ADDI_EX: begin
            bus.alu_src_a = 1'b1;
            bus.alu_src_b = 2'b10;
            nxt           = ADDI_WB;
         end
         ADDI_WB: bus.reg_write = 1'b1;
         default: nxt = FETCH;
      endcase
      if (mem_timeout) nxt = FETCH;
   end
endmodule
